// File: rtl/mem_mmio_responder.sv
// Single-port CPU memory responder: word-addressed RAM plus a small MMIO page
// (LEDs, 32-bit timer with compare/status/irq, sticky bus-error flag).
module mem_mmio_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LED_W     = 4,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      address,
    input  logic [31:0]      data,
    input  logic             wren,
    output logic [31:0]      q,
    output logic [LED_W-1:0] leds,
    output logic             irq,
    output logic             bus_err
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [31:0]      ram_r [DEPTH];
    logic [31:0]      q_r;
    logic [LED_W-1:0] led_r;
    logic [31:0]      count_r;
    logic [31:0]      compare_r;
    logic [2:0]       ctrl_r;
    logic             status_r;
    logic             irq_r;
    logic             bus_err_r;

    logic [31:0]      offset_s;
    logic             in_ram_s;
    logic             mmio_hit_s;
    logic             unmapped_s;
    logic             match_s;
    logic             ram_we_s;
    logic             we_led_s, we_cnt_s, we_cmp_s, we_ctl_s, we_sts_s;
    logic [LED_W-1:0] led_next_s;
    logic [31:0]      count_next_s;
    logic [31:0]      compare_next_s;
    logic [2:0]       ctrl_next_s;
    logic             status_next_s;
    logic             irq_next_s;
    logic [31:0]      rdata_s;

    // Address decode and per-register write strobes
    always_comb begin
        offset_s   = address - MMIO_BASE;
        in_ram_s   = (address < DEPTH_W);
        mmio_hit_s = (address >= MMIO_BASE) && (offset_s < 32'd5);
        unmapped_s = !in_ram_s && !mmio_hit_s;
        ram_we_s   = wren && in_ram_s;
        we_led_s   = wren && mmio_hit_s && (offset_s[2:0] == 3'd0);
        we_cnt_s   = wren && mmio_hit_s && (offset_s[2:0] == 3'd1);
        we_cmp_s   = wren && mmio_hit_s && (offset_s[2:0] == 3'd2);
        we_ctl_s   = wren && mmio_hit_s && (offset_s[2:0] == 3'd3);
        we_sts_s   = wren && mmio_hit_s && (offset_s[2:0] == 3'd4);
    end

    // Next-state for peripheral registers; CPU count write beats the timer, match set beats W1C
    always_comb begin
        match_s = ctrl_r[0] && (count_r == compare_r);

        if (we_cnt_s) begin
            count_next_s = data;
        end else if (ctrl_r[0]) begin
            count_next_s = (match_s && ctrl_r[1]) ? 32'd0 : count_r + 32'd1;
        end else begin
            count_next_s = count_r;
        end

        if (match_s) begin
            status_next_s = 1'b1;
        end else if (we_sts_s && data[0]) begin
            status_next_s = 1'b0;
        end else begin
            status_next_s = status_r;
        end

        led_next_s     = we_led_s ? data[LED_W-1:0] : led_r;
        compare_next_s = we_cmp_s ? data : compare_r;
        ctrl_next_s    = we_ctl_s ? data[2:0] : ctrl_r;
        irq_next_s     = status_next_s & ctrl_next_s[2];
    end

    // Read mux: a write returns the value the target holds after this edge
    always_comb begin
        rdata_s = 32'd0;
        if (in_ram_s) begin
            rdata_s = wren ? data : ram_r[address[AW-1:0]];
        end else if (mmio_hit_s) begin
            case (offset_s[2:0])
                3'd0:    rdata_s[LED_W-1:0] = wren ? led_next_s : led_r;
                3'd1:    rdata_s = wren ? count_next_s : count_r;
                3'd2:    rdata_s = wren ? compare_next_s : compare_r;
                3'd3:    rdata_s[2:0] = wren ? ctrl_next_s : ctrl_r;
                3'd4:    rdata_s[0] = wren ? status_next_s : status_r;
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // RAM storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[address[AW-1:0]] <= data;
        end
    end

    // Registered read data, peripherals and flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r       <= 32'd0;
            led_r     <= '0;
            count_r   <= 32'd0;
            compare_r <= 32'd0;
            ctrl_r    <= 3'd0;
            status_r  <= 1'b0;
            irq_r     <= 1'b0;
            bus_err_r <= 1'b0;
        end else begin
            q_r       <= rdata_s;
            led_r     <= led_next_s;
            count_r   <= count_next_s;
            compare_r <= compare_next_s;
            ctrl_r    <= ctrl_next_s;
            status_r  <= status_next_s;
            irq_r     <= irq_next_s;
            bus_err_r <= bus_err_r | unmapped_s;
        end
    end

    assign q       = q_r;
    assign leds    = led_r;
    assign irq     = irq_r;
    assign bus_err = bus_err_r;

endmodule

// File: tb/tb_mem_mmio_responder.sv
// Directed self-checking bench for mem_mmio_responder.
module tb_mem_mmio_responder;

    localparam int          DEPTH = 1024;
    localparam int          LED_W = 4;
    localparam logic [31:0] MB    = 32'h8000_0000;
    localparam logic [31:0] A_LED = MB;
    localparam logic [31:0] A_CNT = MB + 32'd1;
    localparam logic [31:0] A_CMP = MB + 32'd2;
    localparam logic [31:0] A_CTL = MB + 32'd3;
    localparam logic [31:0] A_STS = MB + 32'd4;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      address;
    logic [31:0]      data;
    logic             wren;
    logic [31:0]      q;
    logic [LED_W-1:0] leds;
    logic             irq;
    logic             bus_err;

    int vectors = 0;
    int errors  = 0;

    mem_mmio_responder #(.DEPTH(DEPTH), .LED_W(LED_W), .MMIO_BASE(MB)) dut (
        .clk(clk), .reset(reset), .address(address), .data(data), .wren(wren),
        .q(q), .leds(leds), .irq(irq), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        address = a;
        data    = d;
        wren    = w;
        @(posedge clk);
        #1;
        wren = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b0;
        address = A_LED;
        data    = 32'd0;
        wren    = 1'b0;
        #12;
        chk("rst_q", q, 32'd0);
        chk("rst_leds", {28'd0, leds}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // RAM write-through and 1-cycle reads
        step(32'd5, 32'hDEAD_BEEF, 1'b1);
        chk("ram_wr_thru", q, 32'hDEAD_BEEF);
        step(32'd6, 32'h1234_5678, 1'b1);
        chk("ram_wr_thru6", q, 32'h1234_5678);
        step(32'd5, 32'd0, 1'b0);
        chk("ram_rd5", q, 32'hDEAD_BEEF);
        step(32'd6, 32'd0, 1'b0);
        chk("ram_rd6", q, 32'h1234_5678);

        // LED register masking
        step(A_LED, 32'hFFFF_FFFA, 1'b1);
        chk("led_wr_q", q, 32'h0000_000A);
        chk("led_out", {28'd0, leds}, 32'h0000_000A);
        step(A_LED, 32'd0, 1'b0);
        chk("led_rd", q, 32'h0000_000A);
        step(A_CTL, 32'hFFFF_FFF8, 1'b1);
        chk("ctl_mask", q, 32'd0);

        // Timer match with auto-clear and irq
        step(A_CMP, 32'd10, 1'b1);
        chk("cmp_wr", q, 32'd10);
        step(A_CNT, 32'd0, 1'b1);
        chk("cnt_wr0", q, 32'd0);
        step(A_CTL, 32'd7, 1'b1);
        chk("ctl_wr7", q, 32'd7);
        for (int i = 0; i < 10; i++) step(A_STS, 32'd0, 1'b0);
        chk("pre_match_irq", {31'd0, irq}, 32'd0);
        chk("pre_match_sts", q, 32'd0);
        step(A_STS, 32'd0, 1'b0);
        chk("match_irq", {31'd0, irq}, 32'd1);
        step(A_CNT, 32'd0, 1'b0);
        chk("autoclr_cnt", q, 32'd0);
        chk("irq_held", {31'd0, irq}, 32'd1);
        step(A_STS, 32'd1, 1'b1);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        chk("w1c_q", q, 32'd0);
        step(A_CTL, 32'd0, 1'b1);

        // Wrap-around, then match at 5 without irq enable
        step(A_CMP, 32'd5, 1'b1);
        step(A_CNT, 32'hFFFF_FFFE, 1'b1);
        step(A_CTL, 32'd1, 1'b1);
        chk("ctl_wr1", q, 32'd1);
        step(A_CNT, 32'd0, 1'b0);
        chk("wrap_fe", q, 32'hFFFF_FFFE);
        step(A_CNT, 32'd0, 1'b0);
        chk("wrap_ff", q, 32'hFFFF_FFFF);
        step(A_CNT, 32'd0, 1'b0);
        chk("wrap_0", q, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(A_STS, 32'd0, 1'b0);
            chk("no_early_match", q, 32'd0);
        end
        step(A_STS, 32'd0, 1'b0);
        chk("match_at5", q, 32'd1);
        chk("irq_disabled", {31'd0, irq}, 32'd0);

        // CPU count write beats increment
        step(A_CNT, 32'd100, 1'b1);
        chk("cnt_wr100", q, 32'd100);
        step(A_CNT, 32'd0, 1'b0);
        chk("cnt_rd100", q, 32'd100);
        step(A_CNT, 32'd0, 1'b0);
        chk("cnt_rd101", q, 32'd101);
        step(A_STS, 32'd1, 1'b1);
        chk("sts_clr", q, 32'd0);
        step(A_CTL, 32'd0, 1'b1);

        // Unmapped accesses
        chk("bus_err_clean", {31'd0, bus_err}, 32'd0);
        step(32'(DEPTH + 3), 32'd0, 1'b0);
        chk("unmap_rd_q", q, 32'd0);
        chk("unmap_bus_err", {31'd0, bus_err}, 32'd1);
        step(32'(DEPTH + 5), 32'h5555_5555, 1'b1);
        chk("unmap_wr_q", q, 32'd0);
        step(MB + 32'd5, 32'h1, 1'b1);
        chk("unmap_mmio_q", q, 32'd0);
        step(32'd5, 32'd0, 1'b0);
        chk("no_alias_wr", q, 32'hDEAD_BEEF);
        chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async_q", q, 32'd0);
        chk("async_leds", {28'd0, leds}, 32'd0);
        chk("async_bus_err", {31'd0, bus_err}, 32'd0);
        chk("async_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(32'd5, 32'd0, 1'b0);
        chk("ram_kept", q, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_mmio_responder.md
Name: mem_mmio_responder

Overview:
- Responder end of the CPU's single-port memory interface (address, data, wren, q).
- Replaces the bare RAM instance with a word-addressed RAM plus a small memory-mapped peripheral page.
- Peripherals: LED output register, 32-bit timer with compare/status/interrupt, and a sticky bus-error flag.
- Preserves the CPU's timing contract: read data appears on q one clock after the address is presented.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; must be a power of two.
- LED_W, 4, width of the LED output register.
- MMIO_BASE, 32'h8000_0000, word address of the peripheral page.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  word address from CPU (instruction fetch, load or store).
- data  in  32  store data.
- wren  in  1  store strobe; a write is performed at the clk edge where wren=1.
- q  out  32  registered read data.
- leds  out  LED_W  LED register value.
- irq  out  1  timer interrupt request.
- bus_err  out  1  sticky unmapped-access flag.

Behaviour:
- Reset (reset=0, asynchronous) clears: q, leds, timer count, compare, ctrl, status, bus_err, irq. RAM contents are not cleared.
- Address map (word addresses):
  - 0..DEPTH-1: RAM.
  - MMIO_BASE+0: LED register. Read/write; low LED_W bits are stored; upper bits read 0.
  - MMIO_BASE+1: timer count (R/W).
  - MMIO_BASE+2: timer compare (R/W).
  - MMIO_BASE+3: ctrl (R/W). bit0 = enable, bit1 = auto-clear on match, bit2 = irq enable; other bits read 0.
  - MMIO_BASE+4: status. bit0 = match, sticky; write 1 to clear.
  - Anything else is unmapped.
- Read latency:
  - q(n+1) = contents of address(n), sampled at edge n. Exactly 1 cycle; no wait states.
  - Every cycle is a read cycle; no read strobe exists.
- Write cycle (wren=1):
  - Target is updated at the edge.
  - q at the next cycle returns the newly written value (write-through). For registers with masking, this is the post-masking value.
  - For status, q returns the post-clear value.
- Unmapped access:
  - A read returns q=0.
  - A write is discarded.
  - Either one sets bus_err=1. bus_err is cleared only by reset.
- Timer:
  - When ctrl.enable=1, count increments by 1 every clk and wraps from 32'hFFFF_FFFF to 0.
  - Match condition: enable=1 and count==compare, evaluated on the pre-increment value. On match, status.bit0 is set at the same edge.
  - If auto-clear=1, count loads 0 at that edge instead of incrementing.
- Simultaneous events:
  - CPU write to count wins over increment and auto-clear in the same cycle.
  - A match set and a W1C clear in the same cycle leave status.bit0=1 (set wins).
  - Writes to compare take effect for the match evaluation of the following cycle.
- irq = status.bit0 & ctrl.bit2. It is registered and follows status with no extra delay, i.e. it updates at the same edge.
- Reset asserted mid-operation: all registers clear immediately, q=0, and any in-flight write is lost.
- RAM index = address[log2(DEPTH)-1:0], used only when address<DEPTH.

Test Plan:
- Write RAM[5]=32'hDEAD_BEEF, then read address 5 -> q=32'hDEAD_BEEF exactly one cycle after the address is presented; the write cycle itself also returns 32'hDEAD_BEEF on the following cycle.
- Write 32'hFFFF_FFFA to MMIO_BASE+0 -> leds=4'hA; reading back gives q=32'h0000_000A.
- Set compare=10, ctrl=3'b111, count=0 -> at the edge where count==10, status.bit0=1, irq=1 and count=0. Writing 1 to status clears irq on the next edge.
- Set count=32'hFFFF_FFFE, compare=5, ctrl=1 -> after 2 cycles count=0; no match fires until count reaches 5.
- Write count=100 in the same cycle it would increment -> count=100; the next cycle reads 100 or 101 according to the 1-cycle latency rule.
- Read address DEPTH+3 -> q=0 and bus_err=1. Pull reset low asynchronously mid-run -> bus_err=0, leds=0, q=0 before the next clock edge.
